// File: rtl/sort_job_scheduler_if.sv
// Requester, sort-array and drain-channel signals of the
// shared sort job scheduler.
interface sort_job_scheduler_if #(
  parameter int N    = 8,
  parameter int DW   = 16,
  parameter int NREQ = 2
);
  localparam int AW = $clog2(N);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    in_valid;
  logic [NREQ*DW-1:0] in_data;
  logic [NREQ-1:0]    in_ready;

  logic               sort_wr_en;
  logic [AW-1:0]      sort_wr_addr;
  logic [DW-1:0]      sort_wr_data;
  logic               sort_en;
  logic               sort_round_done;
  logic [AW-1:0]      sort_rd_addr;
  logic [DW-1:0]      sort_rd_data;

  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;
  logic               out_last;
  logic [IW-1:0]      out_id;

  modport slave (
    input  req, in_valid, in_data,
    input  sort_round_done, sort_rd_data,
    input  out_ready,
    output gnt, in_ready,
    output sort_wr_en, sort_wr_addr, sort_wr_data,
    output sort_en, sort_rd_addr,
    output out_valid, out_data, out_last, out_id
  );

  modport master (
    output req, in_valid, in_data,
    output sort_round_done, sort_rd_data,
    output out_ready,
    input  gnt, in_ready,
    input  sort_wr_en, sort_wr_addr, sort_wr_data,
    input  sort_en, sort_rd_addr,
    input  out_valid, out_data, out_last, out_id
  );
endinterface

// File: rtl/sort_job_scheduler.sv
// Round-robin scheduler sharing one odd-even sort array:
// load the winner's N elements, sort N/2 rounds, drain back.
module sort_job_scheduler #(
  parameter int N    = 8,
  parameter int DW   = 16,
  parameter int NREQ = 2
) (
  input logic             clk,
  input logic             rst_n,
  sort_job_scheduler_if.slave bus
);
  localparam int AW = $clog2(N);
  localparam int IW = $clog2(NREQ);
  localparam int RW = $clog2(N/2 + 1);

  typedef enum logic [1:0] {
    IDLE, LOAD, SORT, DRAIN
  } state_t;

  state_t          state;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] in_ready;
  logic [IW-1:0]   out_id;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   win;
  logic [IW-1:0]   nxt_ptr;
  logic            found;
  logic [AW-1:0]   idx;
  logic [RW-1:0]   rnd;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [DW-1:0]   sel_data;
  logic            sel_valid;
  logic            sort_en;
  logic            out_valid;

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (int'(rr_ptr) + k) % NREQ;
      if (!found && bus.req[c]) begin
        found = 1'b1;
        win   = IW'(c);
      end
    end
    nxt_ptr = (int'(win) == NREQ-1) ? '0 : win + 1'b1;
  end

  // in_ready is one-hot on the winner during LOAD only
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (in_ready[i]) sel_data = bus.in_data[i*DW +: DW];
    end
  end
  assign sel_valid = |(bus.in_valid & in_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      in_ready  <= '0;
      out_id    <= '0;
      rr_ptr    <= '0;
      idx       <= '0;
      rnd       <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      sort_en   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            gnt      <= NREQ'(1) << win;
            in_ready <= NREQ'(1) << win;
            out_id   <= win;
            rr_ptr   <= nxt_ptr;
            idx      <= '0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (sel_valid) begin
            wr_en   <= 1'b1;
            wr_addr <= idx;
            wr_data <= sel_data;
            if (idx == AW'(N-1)) begin
              idx      <= '0;
              rnd      <= '0;
              in_ready <= '0;
              state    <= SORT;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        SORT: begin
          // enable one cycle late so the last write lands first
          sort_en <= 1'b1;
          if (sort_en && bus.sort_round_done) begin
            rnd <= rnd + 1'b1;
            if (rnd == RW'(N/2 - 1)) begin
              sort_en   <= 1'b0;
              out_valid <= 1'b1;
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (idx == AW'(N-1)) begin
              idx       <= '0;
              gnt       <= '0;
              out_valid <= 1'b0;
              state     <= IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt          = gnt;
  assign bus.in_ready     = in_ready;
  assign bus.out_id       = out_id;
  assign bus.sort_wr_en   = wr_en;
  assign bus.sort_wr_addr = wr_addr;
  assign bus.sort_wr_data = wr_data;
  assign bus.sort_en      = sort_en;
  assign bus.sort_rd_addr = (state == DRAIN) ? idx : '0;
  assign bus.out_valid    = out_valid;
  assign bus.out_data     = out_valid ? bus.sort_rd_data : '0;
  assign bus.out_last     = out_valid && (idx == AW'(N-1));
endmodule
